// File: rtl/cfg_avmm_arbiter.sv
// Round-robin arbiter that shares one AVMM configuration slave port among NREQ masters.
// One transaction in flight; Avalon waitrequest handshake on both sides; read data is
// routed back to the requester that owns the outstanding read.
// Optional feature: define AVMM_ARB_TIMEOUT_EN to enable the read-response timeout.
module cfg_avmm_arbiter #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               i_cfg_avmm_clk,
    input  logic               i_cfg_avmm_rst_n,
    input  logic [NREQ*17-1:0] i_req_addr,
    input  logic [NREQ*4-1:0]  i_req_byte_en,
    input  logic [NREQ*32-1:0] i_req_wdata,
    input  logic [NREQ-1:0]    i_req_read,
    input  logic [NREQ-1:0]    i_req_write,
    output logic [NREQ-1:0]    o_req_waitreq,
    output logic [NREQ-1:0]    o_req_rdatavld,
    output logic [31:0]        o_req_rdata,
    output logic [16:0]        o_cfg_avmm_addr,
    output logic [3:0]         o_cfg_avmm_byte_en,
    output logic [31:0]        o_cfg_avmm_wdata,
    output logic               o_cfg_avmm_read,
    output logic               o_cfg_avmm_write,
    input  logic               i_cfg_avmm_waitreq,
    input  logic               i_cfg_avmm_rdatavld,
    input  logic [31:0]        i_cfg_avmm_rdata,
    output logic               o_timeout_err
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StCmd, StRdWait} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [16:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            read_q, read_d;
    logic            write_q, write_d;

    logic            hit;
    logic [IdxW-1:0] hit_idx;
    logic [IdxW-1:0] cand;
    logic            accept;
    logic            timeout;

    // Round-robin search: first active requester at or after the pointer.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NREQ);
            if (!hit && (i_req_read[cand] || i_req_write[cand])) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    // Next-state logic: grant/latch in idle, handshake in cmd, wait for data in rdwait.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        read_d  = read_q;
        write_d = write_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    gnt_d   = hit_idx;
                    addr_d  = i_req_addr[32'(hit_idx)*17 +: 17];
                    be_d    = i_req_byte_en[32'(hit_idx)*4 +: 4];
                    wdata_d = i_req_wdata[32'(hit_idx)*32 +: 32];
                    // Read together with write counts as a write.
                    write_d = i_req_write[hit_idx];
                    read_d  = i_req_read[hit_idx] & ~i_req_write[hit_idx];
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (!i_cfg_avmm_waitreq) begin
                    accept  = 1'b1;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ptr_d   = (gnt_q == IdxW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = read_q ? StRdWait : StIdle;
                end
            end
            StRdWait: begin
                if (i_cfg_avmm_rdatavld || timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and command registers; strobes drop immediately on reset.
    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    // Requester-side responses: only the granted requester ever sees a handshake or data.
    always_comb begin
        o_req_waitreq  = '1;
        o_req_rdatavld = '0;
        o_req_rdata    = '0;
        if (accept) begin
            o_req_waitreq[gnt_q] = 1'b0;
        end
        if (state_q == StRdWait) begin
            o_req_rdatavld[gnt_q] = i_cfg_avmm_rdatavld | timeout;
            o_req_rdata = (timeout && !i_cfg_avmm_rdatavld) ? 32'hDEAD_BEEF : i_cfg_avmm_rdata;
        end
    end

    assign o_cfg_avmm_addr    = addr_q;
    assign o_cfg_avmm_byte_en = be_q;
    assign o_cfg_avmm_wdata   = wdata_q;
    assign o_cfg_avmm_read    = read_q;
    assign o_cfg_avmm_write   = write_q;

`ifdef AVMM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Cycles spent in rdwait; held at zero elsewhere so every read starts from zero.
    always_comb begin
        cnt_d   = (state_q == StRdWait) ? cnt_q + 1'b1 : '0;
        timeout = (state_q == StRdWait) && !i_cfg_avmm_rdatavld &&
                  ((32'(cnt_q) + 32'd1) == TIMEOUT_CYC);
        err_d   = err_q | timeout;
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_timeout_err = err_q;
`else
    assign timeout       = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_avmm_arbiter.sv
// Self-checking bench for cfg_avmm_arbiter: transaction-level reference model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_cfg_avmm_arbiter;

    localparam int unsigned NREQ = 2;
`ifdef AVMM_ARB_TIMEOUT_EN
    localparam int unsigned TO    = 16;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TO    = 255;
    localparam bit          TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ*17-1:0] req_addr = '0;
    logic [NREQ*4-1:0]  req_be = '0;
    logic [NREQ*32-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_read = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ-1:0]    waitreq;
    logic [NREQ-1:0]    rdatavld;
    logic [31:0]        rdata;
    logic [16:0]        c_addr;
    logic [3:0]         c_be;
    logic [31:0]        c_wdata;
    logic               c_read;
    logic               c_write;
    logic               s_waitreq = 1'b0;
    logic               s_vld = 1'b0;
    logic [31:0]        s_rdata = '0;
    logic               terr;

    cfg_avmm_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .i_cfg_avmm_clk     (clk),
        .i_cfg_avmm_rst_n   (rst_n),
        .i_req_addr         (req_addr),
        .i_req_byte_en      (req_be),
        .i_req_wdata        (req_wdata),
        .i_req_read         (req_read),
        .i_req_write        (req_write),
        .o_req_waitreq      (waitreq),
        .o_req_rdatavld     (rdatavld),
        .o_req_rdata        (rdata),
        .o_cfg_avmm_addr    (c_addr),
        .o_cfg_avmm_byte_en (c_be),
        .o_cfg_avmm_wdata   (c_wdata),
        .o_cfg_avmm_read    (c_read),
        .o_cfg_avmm_write   (c_write),
        .i_cfg_avmm_waitreq (s_waitreq),
        .i_cfg_avmm_rdatavld(s_vld),
        .i_cfg_avmm_rdata   (s_rdata),
        .o_timeout_err      (terr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- reference model: one transaction record ----------------
    bit          m_busy = 0, m_acc = 0, m_wr = 0, m_err = 0;
    int          m_own = 0, m_ptr = 0, m_age = 0;
    logic [16:0] m_addr = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_wdata = '0;
    int          m_gnt_log[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_acc = 0; m_ptr = 0; m_age = 0; m_err = 0;
        end else if (!m_busy) begin
            bit found;
            found = 0;
            for (int i = 0; i < NREQ; i++) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (!found && (req_read[k] || req_write[k])) begin
                    found   = 1;
                    m_busy  = 1;
                    m_acc   = 0;
                    m_own   = k;
                    m_wr    = req_write[k];
                    m_addr  = req_addr[k*17 +: 17];
                    m_be    = req_be[k*4 +: 4];
                    m_wdata = req_wdata[k*32 +: 32];
                    m_gnt_log.push_back(k);
                end
            end
        end else if (!m_acc) begin
            if (!s_waitreq) begin
                m_ptr = (m_own + 1) % NREQ;
                if (m_wr) m_busy = 0;
                else begin m_acc = 1; m_age = 1; end
            end
        end else begin
            if (s_vld) m_busy = 0;
            else if (TO_EN && m_age == int'(TO)) begin m_busy = 0; m_err = 1; end
            else m_age++;
        end
    end

    // Compare DUT against the model every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [NREQ-1:0] e_wq, e_vld;
            logic            e_rd, e_wr, to_now;
            e_rd   = m_busy && !m_acc && !m_wr;
            e_wr   = m_busy && !m_acc && m_wr;
            e_wq   = '1;
            e_vld  = '0;
            to_now = TO_EN && m_busy && m_acc && !s_vld && (m_age == int'(TO));
            if (m_busy && !m_acc && !s_waitreq) e_wq[m_own] = 1'b0;
            if (m_busy && m_acc) e_vld[m_own] = s_vld | to_now;
            chk("cyc_read", c_read, e_rd);
            chk("cyc_write", c_write, e_wr);
            chk("cyc_waitreq", waitreq, e_wq);
            chk("cyc_rdatavld", rdatavld, e_vld);
            chk("cyc_timeout_err", terr, m_err);
            if (e_rd || e_wr) begin
                chk("cyc_addr", c_addr, m_addr);
                chk("cyc_be", c_be, m_be);
                chk("cyc_wdata", c_wdata, m_wdata);
            end
            if (e_vld != 0) chk("cyc_rdata", rdata, to_now ? 32'hDEAD_BEEF : s_rdata);
        end
    end

    // ---------------- observation of DUT activity for directed checks ----------------
    int          wr_cycles = 0, rd_cycles = 0, vld_cnt = 0, cyc_acc = 0, cyc_v = 0;
    int          wq_low[NREQ];
    int          dut_gnt[$];
    logic [16:0] last_addr = '0;
    logic [31:0] last_wdata = '0, last_rdata = '0;
    logic [NREQ-1:0] last_vld = '0;

    initial for (int i = 0; i < NREQ; i++) wq_low[i] = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (c_write) begin wr_cycles++; last_addr = c_addr; last_wdata = c_wdata; end
            if (c_read) rd_cycles++;
            if (rdatavld != 0) begin
                vld_cnt++; last_vld = rdatavld; last_rdata = rdata; cyc_v = cyc;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!waitreq[i]) begin wq_low[i]++; dut_gnt.push_back(i); cyc_acc = cyc; end
            end
        end
    end

    task automatic clear_obs();
        wr_cycles = 0; rd_cycles = 0; vld_cnt = 0; last_vld = '0;
        for (int i = 0; i < NREQ; i++) wq_low[i] = 0;
        dut_gnt.delete();
        m_gnt_log.delete();
    endtask

    // ---------------- downstream slave ----------------
    bit          slv_en = 1;
    int          slv_stall = 0, slv_lat = 1, stall_cnt = 0, rd_pend = 0;
    logic [31:0] slv_data = '0;

    always begin
        @(posedge clk);
        #1;
        if (slv_en) begin
            s_vld = 1'b0;
            if (rd_pend > 0) begin
                rd_pend--;
                if (rd_pend == 0) begin s_vld = 1'b1; s_rdata = slv_data; end
            end
            if (c_read || c_write) begin
                if (stall_cnt < slv_stall) begin s_waitreq = 1'b1; stall_cnt++; end
                else begin
                    s_waitreq = 1'b0; stall_cnt = 0;
                    if (c_read && slv_lat > 0) rd_pend = slv_lat;
                end
            end else s_waitreq = 1'b0;
        end
    end

    // ---------------- requester driver ----------------
    task automatic xact(input int k, input bit wr, input logic [16:0] a, input logic [31:0] d);
        int n;
        req_addr[k*17 +: 17]  = a;
        req_be[k*4 +: 4]      = 4'hF;
        req_wdata[k*32 +: 32] = d;
        req_write[k]          = wr;
        req_read[k]           = !wr;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!waitreq[k]) break;
            n++;
            if (n > 300) begin chk("accept_timeout", waitreq[k], 1'b0); break; end
        end
        @(posedge clk);
        #1;
        req_write[k] = 1'b0;
        req_read[k]  = 1'b0;
    endtask

    task automatic wait_vld(input int limit);
        int n;
        n = 0;
        while (vld_cnt == 0 && n < limit) begin @(posedge clk); #2; n++; end
        if (vld_cnt == 0) chk("rdatavld_timeout", rdatavld, 2'b01);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rd_pend = 0; stall_cnt = 0; s_vld = 1'b0; s_waitreq = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic contender(input int k, input int n);
        for (int i = 0; i < n; i++) xact(k, 1'b1, 17'((k << 12) | i), $urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_write", c_write, 1'b0);
        chk("rst_read", c_read, 1'b0);
        chk("rst_addr", c_addr, 17'h0);
        chk("rst_waitreq", waitreq, 2'b11);
        chk("rst_rdatavld", rdatavld, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_timeout_err", terr, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write from requester 0
        clear_obs();
        xact(0, 1'b1, 17'h00208, 32'h1234_5678);
        repeat (3) @(posedge clk); #1;
        chk("wr_strobe_cycles", wr_cycles, 1);
        chk("wr_addr", last_addr, 17'h00208);
        chk("wr_data", last_wdata, 32'h1234_5678);
        chk("wr_req0_ack", wq_low[0], 1);
        chk("wr_req1_ack", wq_low[1], 0);

        // Read with 5-cycle slave stall, data 3 cycles after accept (pointer now at 1)
        clear_obs();
        slv_stall = 5; slv_lat = 3; slv_data = 32'hA5A5_0F0F;
        xact(1, 1'b0, 17'h1_0040, 32'h0);
        wait_vld(20);
        repeat (3) @(posedge clk); #1;
        chk("rd_strobe_cycles", rd_cycles, 6);
        chk("rd_vld_pulses", vld_cnt, 1);
        chk("rd_vld_owner", last_vld, 2'b10);
        chk("rd_data", last_rdata, 32'hA5A5_0F0F);
        chk("rd_lat", cyc_v - cyc_acc, 3);
        slv_stall = 0; slv_lat = 1;

        // Spurious downstream rdatavld while idle
        clear_obs();
        slv_en = 0;
        s_vld = 1'b1; s_rdata = 32'hFFFF_0000;
        repeat (3) @(posedge clk); #1;
        s_vld = 1'b0;
        slv_en = 1;
        chk("spur_vld", vld_cnt, 0);
        xact(0, 1'b1, 17'h00010, 32'hCAFE_0001);
        repeat (2) @(posedge clk); #1;
        chk("spur_next_write", wr_cycles, 1);

        // Contention: both requesters write continuously from reset
        do_reset();
        @(posedge clk); #1;
        clear_obs();
        fork
            contender(0, 50);
            contender(1, 50);
        join
        repeat (3) @(posedge clk); #1;
        chk("cont_total", dut_gnt.size(), 100);
        chk("cont_model_total", m_gnt_log.size(), 100);
        if (dut_gnt.size() >= 4) begin
            chk("cont_g0", dut_gnt[0], 0);
            chk("cont_g1", dut_gnt[1], 1);
            chk("cont_g2", dut_gnt[2], 0);
            chk("cont_g3", dut_gnt[3], 1);
        end
        chk("cont_req0_done", wq_low[0], 50);
        chk("cont_req1_done", wq_low[1], 50);
        begin
            int rep;
            rep = 0;
            for (int i = 1; i < dut_gnt.size(); i++) if (dut_gnt[i] == dut_gnt[i-1]) rep++;
            chk("cont_alternate", rep, 0);
        end

        // Reset during RDWAIT, then the next grant goes to requester 0
        slv_lat = 0;
        xact(0, 1'b0, 17'h00300, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_read", c_read, 1'b0);
        chk("rstmid_waitreq", waitreq, 2'b11);
        chk("rstmid_rdatavld", rdatavld, 2'b00);
        rd_pend = 0; stall_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        slv_lat = 1;
        @(posedge clk); #1;
        clear_obs();
        fork
            xact(0, 1'b1, 17'h00400, 32'h0000_0A0A);
            xact(1, 1'b1, 17'h00500, 32'h0000_0B0B);
        join
        repeat (2) @(posedge clk); #1;
        if (dut_gnt.size() > 0) chk("rstmid_first_grant", dut_gnt[0], 0);
        else chk("rstmid_no_grant", dut_gnt.size(), 2);

`ifdef AVMM_ARB_TIMEOUT_EN
        // Read that never returns data
        clear_obs();
        slv_lat = 0;
        xact(0, 1'b0, 17'h00600, 32'h0);
        wait_vld(40);
        repeat (2) @(posedge clk); #1;
        chk("to_lat", cyc_v - cyc_acc, 16);
        chk("to_data", last_rdata, 32'hDEAD_BEEF);
        chk("to_owner", last_vld, 2'b01);
        chk("to_err", terr, 1'b1);
        slv_lat = 1;
        xact(1, 1'b1, 17'h00700, 32'h0);
        repeat (3) @(posedge clk); #1;
        chk("to_err_sticky", terr, 1'b1);
`else
        chk("no_to_err", terr, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
